// File: rtl/operand_mux_pipe.sv
// Registered ALU B-operand selector with a valid/ready handshake.
// A one-entry skid buffer lets upstream stream at full rate under back-pressure.
// in_ready comes straight from a register. xfer_count counts delivered operands
// for debug visibility.
module operand_mux_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic             imm_sext,
    input  logic [WIDTH-1:0] norm,
    input  logic [IMM_W-1:0] immi,
    input  logic [WIDTH-1:0] fwd_alu,
    input  logic [WIDTH-1:0] fwd_mem,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] xfer_count
);

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] sel_data;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic xfer;
    logic out_free;

    // A full-width immediate has no bits to extend, so it passes through unchanged.
    if (IMM_W < WIDTH) begin : g_imm_extend
        assign imm_ext = {{(WIDTH - IMM_W){imm_sext & immi[IMM_W-1]}}, immi};
    end else begin : g_imm_pass
        assign imm_ext = immi;
    end

    // Source select; only consumed on the accept cycle.
    always_comb begin
        sel_data = norm;
        unique case (sel)
            2'd0: sel_data = norm;
            2'd1: sel_data = imm_ext;
            2'd2: sel_data = fwd_alu;
            2'd3: sel_data = fwd_mem;
            default: sel_data = norm;
        endcase
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid_q & out_ready;
    assign out_free = ~out_valid_q | out_ready;

    // Next-state for the output register, the skid buffer and the transfer counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        // A transfer in a flush cycle still counts.
        cnt_d        = xfer ? cnt_q + CNT_W'(1) : cnt_q;

        if (flush) begin
            // Held beats and any beat accepted this cycle are discarded; data may stay.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Skid is older than anything upstream; in_ready is low, so no accept.
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = sel_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new beat in the skid, keep out stable.
            skid_d       = sel_data;
            skid_valid_d = 1'b1;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out        = out_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Directed bench for operand_mux_pipe: extension, streaming, skid, flush,
// counter wrap and asynchronous reset.
module tb_operand_mux_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  sel;
    logic        imm_sext;
    logic [31:0] norm, fwd_alu, fwd_mem;
    logic [15:0] immi;
    logic        flush;
    logic        out_ready;

    // Main instance: 32-bit datapath, 16-bit counter.
    logic        in_ready, out_valid;
    logic [31:0] out;
    logic [15:0] xfer_count;

    // Narrow-counter instance driven by the same inputs.
    logic        c4_in_ready, c4_out_valid;
    logic [31:0] c4_out;
    logic [3:0]  c4_xfer_count;

    // Full-width immediate instance (IMM_W == WIDTH).
    logic        n_in_ready, n_out_valid;
    logic [15:0] n_out;
    logic [15:0] n_xfer_count;

    int ncmp = 0;
    int nerr = 0;

    operand_mux_pipe #(.WIDTH(32), .IMM_W(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .imm_sext(imm_sext), .norm(norm), .immi(immi),
        .fwd_alu(fwd_alu), .fwd_mem(fwd_mem), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .xfer_count(xfer_count)
    );

    operand_mux_pipe #(.WIDTH(32), .IMM_W(16), .CNT_W(4)) dut_c4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c4_in_ready),
        .sel(sel), .imm_sext(imm_sext), .norm(norm), .immi(immi),
        .fwd_alu(fwd_alu), .fwd_mem(fwd_mem), .flush(flush),
        .out_valid(c4_out_valid), .out_ready(out_ready), .out(c4_out),
        .xfer_count(c4_xfer_count)
    );

    operand_mux_pipe #(.WIDTH(16), .IMM_W(16), .CNT_W(16)) dut_n (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
        .sel(sel), .imm_sext(imm_sext), .norm(norm[15:0]), .immi(immi),
        .fwd_alu(fwd_alu[15:0]), .fwd_mem(fwd_mem[15:0]), .flush(flush),
        .out_valid(n_out_valid), .out_ready(out_ready), .out(n_out),
        .xfer_count(n_xfer_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 0; sel = 0; imm_sext = 0; norm = 0; immi = 0;
        fwd_alu = 0; fwd_mem = 0; flush = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst out_valid", out_valid, 0);
        check_eq("rst out", out, 0);
        check_eq("rst in_ready", in_ready, 1);
        check_eq("rst xfer_count", xfer_count, 0);
        reset = 1'b0;

        // Immediate extension.
        in_valid = 1; sel = 1; immi = 16'h8001; imm_sext = 1; out_ready = 1;
        step();
        check_eq("sext out", out, 32'hFFFF8001);
        check_eq("sext out_valid", out_valid, 1);
        check_eq("full-width imm sext", n_out, 16'h8001);
        imm_sext = 0;
        step();
        check_eq("zext out", out, 32'h00008001);
        check_eq("full-width imm zext", n_out, 16'h8001);
        in_valid = 0;
        step();
        check_eq("drain out_valid", out_valid, 0);
        check_eq("two xfers", xfer_count, 2);

        // Full-rate stream across the non-immediate sources.
        do_reset();
        norm = 1; fwd_alu = 2; fwd_mem = 3; in_valid = 1; out_ready = 1;
        sel = 0; step();
        check_eq("stream norm", out, 1);
        check_eq("stream in_ready 0", in_ready, 1);
        sel = 2; step();
        check_eq("stream fwd_alu", out, 2);
        sel = 3; step();
        check_eq("stream fwd_mem", out, 3);
        check_eq("stream in_ready 2", in_ready, 1);
        sel = 0; step();
        check_eq("stream norm again", out, 1);
        in_valid = 0; step();
        check_eq("stream xfer_count", xfer_count, 4);
        check_eq("stream drained", out_valid, 0);

        // Back-pressure fills the skid, then drains in order.
        do_reset();
        out_ready = 0; in_valid = 1; sel = 0; norm = 5;
        step();
        check_eq("A on out", out, 5);
        check_eq("A ready", in_ready, 1);
        norm = 6; step();
        check_eq("A held", out, 5);
        check_eq("skid full in_ready", in_ready, 0);
        in_valid = 0; out_ready = 1;
        step();
        check_eq("B on out", out, 6);
        check_eq("B valid", out_valid, 1);
        check_eq("ready back", in_ready, 1);
        check_eq("A counted", xfer_count, 1);
        step();
        check_eq("skid drained", out_valid, 0);
        check_eq("A,B counted", xfer_count, 2);

        // Flush with out and skid full; C is offered but never delivered.
        do_reset();
        out_ready = 0; in_valid = 1; norm = 5; step();
        norm = 6; step();
        norm = 7; flush = 1; step();
        check_eq("flush out_valid", out_valid, 0);
        check_eq("flush in_ready", in_ready, 1);
        flush = 0; in_valid = 0; out_ready = 1;
        step();
        check_eq("no C delivered", out_valid, 0);
        check_eq("flush count", xfer_count, 0);
        // Beat accepted into the skid during flush is discarded.
        out_ready = 0; in_valid = 1; norm = 8; step();
        norm = 9; flush = 1; step();
        check_eq("flush accept drop", out_valid, 0);
        flush = 0; in_valid = 0; out_ready = 1; step();
        check_eq("dropped beat absent", out_valid, 0);
        // Transfer during the flush cycle still counts.
        in_valid = 1; norm = 10; step();
        check_eq("pre-flush out", out, 10);
        in_valid = 0; flush = 1; step();
        check_eq("flush xfer counted", xfer_count, 1);
        check_eq("flush xfer out_valid", out_valid, 0);
        flush = 0;

        // 17 transfers: 4-bit counter wraps to 1.
        do_reset();
        in_valid = 1; out_ready = 1; sel = 0;
        for (int i = 0; i < 17; i++) begin
            norm = 32'(i + 100);
            step();
            check_eq("wrap stream data", out, 32'(i + 100));
        end
        in_valid = 0; step();
        check_eq("c4 wrap", c4_xfer_count, 1);
        check_eq("c16 no wrap", xfer_count, 17);

        // Asynchronous reset mid-cycle with out and skid full.
        out_ready = 0; in_valid = 1; norm = 5; step();
        norm = 6; step();
        in_valid = 0;
        check_eq("pre-reset full", in_ready, 0);
        check_eq("pre-reset count", xfer_count, 17);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async out_valid", out_valid, 0);
        check_eq("async out", out, 0);
        check_eq("async in_ready", in_ready, 1);
        check_eq("async xfer_count", xfer_count, 0);
        step();
        reset = 1'b0;
        step();
        check_eq("post-reset idle", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/operand_mux_pipe.md
Name: operand_mux_pipe

Overview:
- Parametrised, registered operand selector for the datapath's ALU B-input path.
- Chooses one of four sources each cycle:
  - register-file data;
  - sign- or zero-extended immediate;
  - ALU forward;
  - memory forward.
- Registers the result behind a valid/ready handshake, with a one-entry skid buffer so upstream can stream at full rate under back-pressure.
- Provides a synchronous flush for branch redirect and a wrapping count of delivered operands for debug.

Parameters:
- WIDTH, 32, datapath width in bits of norm, fwd_alu, fwd_mem and out.
- IMM_W, 16, immediate field width. Legal range is 1 <= IMM_W <= WIDTH.
- CNT_W, 16, width of the delivered-operand counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a beat.
- in_ready  output  1  block can accept a beat this cycle.
- sel  input  2  source select: 0 norm, 1 immi, 2 fwd_alu, 3 fwd_mem.
- imm_sext  input  1  1 = sign-extend immi, 0 = zero-extend.
- norm  input  WIDTH  register-file operand.
- immi  input  IMM_W  immediate field.
- fwd_alu  input  WIDTH  EX-stage forward value.
- fwd_mem  input  WIDTH  MEM-stage forward value.
- flush  input  1  synchronous discard of all held beats.
- out_valid  output  1  out holds a valid operand.
- out_ready  input  1  downstream accepts out this cycle.
- out  output  WIDTH  selected operand.
- xfer_count  output  CNT_W  number of completed output transfers, modulo 2^CNT_W.

Behaviour:
- Selection (combinational, sampled at accept):
  - sel=1 extends immi to WIDTH: copy immi[IMM_W-1] when imm_sext=1, zeros otherwise.
  - When IMM_W==WIDTH, immi passes through unchanged.
  - sel and imm_sext are sampled only on the accept cycle.
- Accept: in_valid & in_ready. Transfer: out_valid & out_ready.
- in_ready = ~skid_valid, driven from a register. in_ready is never combinationally dependent on out_ready.
- Reset (asynchronous): out_valid=0, out=0, skid_valid=0, skid data=0, xfer_count=0. Hence in_ready=1 while reset is asserted and after release.
- Latency: an accepted beat appears on out on the next clock edge if the output register is free. Throughput is 1 beat/cycle when out_ready is held high.
- Per-edge rules, when flush=0:
  - Output register free (out_valid=0, or transfer this cycle) and skid empty: an accepted beat loads out and sets out_valid=1. With no accept, out_valid=0.
  - Output register free and skid full: skid data moves to out with out_valid=1, and skid_valid=0. No accept is possible because in_ready=0.
  - Output stalled (out_valid=1, out_ready=0) and accept: the beat goes to the skid and skid_valid=1. out is unchanged.
  - Output stalled and no accept: everything holds.
- Ordering: beats leave in acceptance order. No beat is ever dropped or duplicated except by flush.
- out stays stable while out_valid=1 and out_ready=0.
- Flush (highest priority, synchronous): on the next edge out_valid=0 and skid_valid=0.
  - A beat accepted in the flush cycle is discarded.
  - A transfer in the flush cycle still counts in xfer_count.
  - out data need not be cleared.
- xfer_count increments by 1 on every transfer and wraps from 2^CNT_W-1 to 0. It is not cleared by flush.
- Reset mid-stream: all held beats are lost immediately and the counter clears.

Test Plan:
- Reset, then one beat with sel=1, immi=16'h8001, imm_sext=1, out_ready=1 -> next cycle out=32'hFFFF8001, out_valid=1. Repeat with imm_sext=0 -> out=32'h00008001.
- Stream sel=0,2,3,0 with norm=1, fwd_alu=2, fwd_mem=3, out_ready=1 and in_valid held high -> out=1,2,3,1 on consecutive cycles, in_ready stays 1, xfer_count=4.
- Hold out_ready=0 and send beats A=5, B=6 -> A on out, B in skid, in_ready=0 on the cycle after B. Then raise out_ready -> A, then B, delivered on consecutive cycles; in_ready returns to 1.
- Fill out and skid, then assert flush with in_valid=1 carrying C=7 -> next cycle out_valid=0, in_ready=1, and C is never delivered.
- With CNT_W=4 and 17 transfers -> xfer_count=1.
- Assert reset asynchronously mid-cycle while out and skid are full -> out_valid=0, out=0, in_ready=1, xfer_count=0 immediately, without waiting for a clock edge.
